// File: rtl/reg_write_bridge_if.sv
// Host-link / register-write bundle for reg_write_bridge.
// slave is the bridge's view; master is the host/consumer side.
interface reg_write_bridge_if;
    logic        frame_start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] status_reg;
    logic [11:0] wr_reg;
    logic [3:0]  wr_reg_addr;
    logic        wr_reg_changed;
    logic        busy;

    modport slave (
        input  frame_start, in_data, in_valid, tx_ready, status_reg,
        output in_ready, tx_data, tx_valid, wr_reg, wr_reg_addr,
               wr_reg_changed, busy
    );

    modport master (
        output frame_start, in_data, in_valid, tx_ready, status_reg,
        input  in_ready, tx_data, tx_valid, wr_reg, wr_reg_addr,
               wr_reg_changed, busy
    );
endinterface

// File: rtl/reg_write_bridge.sv
// Decodes host command frames into toggle-strobed 12-bit register writes
// and streams a 32-bit status snapshot back to the host, MSB byte first.
module reg_write_bridge #(
    parameter int HOLD_CYCLES = 256,
    parameter int HOLD_W      = 9
) (
    input  logic             clk,
    input  logic             reset,
    reg_write_bridge_if.slave bus
);

    typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, HOLD, RD_TX} state_t;

    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_READ  = 4'h2;

    state_t            state_q, state_d;
    logic [3:0]        pend_addr_q, pend_addr_d;
    logic [3:0]        pend_hi_q, pend_hi_d;
    logic [11:0]       wr_reg_q, wr_reg_d;
    logic [3:0]        wr_addr_q, wr_addr_d;
    logic              changed_q, changed_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [1:0]        tx_cnt_q, tx_cnt_d;

    logic in_ready;
    logic accept;
    logic tx_fire;

    // A frame boundary blocks byte acceptance so a coincident byte is dropped.
    assign in_ready = (state_q == IDLE || state_q == WR_HI || state_q == WR_LO)
                      && !bus.frame_start;
    assign accept   = bus.in_valid && in_ready;
    assign tx_fire  = (state_q == RD_TX) && bus.tx_ready;

    // Next-state and datapath decode; the whole write commits on one edge.
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_hi_d   = pend_hi_q;
        wr_reg_d    = wr_reg_q;
        wr_addr_d   = wr_addr_q;
        changed_d   = changed_q;
        hold_cnt_d  = hold_cnt_q;
        shift_d     = shift_q;
        tx_cnt_d    = tx_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (bus.in_data[7:4])
                        CMD_WRITE: begin
                            pend_addr_d = bus.in_data[3:0];
                            state_d     = WR_HI;
                        end
                        CMD_READ: begin
                            shift_d  = bus.status_reg;
                            tx_cnt_d = 2'd0;
                            state_d  = RD_TX;
                        end
                        default: ;
                    endcase
                end
            end
            WR_HI: begin
                if (accept) begin
                    pend_hi_d = bus.in_data[3:0];
                    state_d   = WR_LO;
                end
            end
            WR_LO: begin
                if (accept) begin
                    wr_reg_d   = {pend_hi_q, bus.in_data};
                    wr_addr_d  = pend_addr_q;
                    changed_d  = ~changed_q;
                    hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            RD_TX: begin
                if (tx_fire) begin
                    shift_d  = {shift_q[23:0], 8'h00};
                    tx_cnt_d = tx_cnt_q + 2'd1;
                    if (tx_cnt_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame boundary aborts anything except a committed write's hold.
        if (bus.frame_start && state_q != HOLD) begin
            state_d  = IDLE;
            shift_d  = '0;
            tx_cnt_d = 2'd0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
            pend_hi_q   <= '0;
            wr_reg_q    <= '0;
            wr_addr_q   <= '0;
            changed_q   <= 1'b0;
            hold_cnt_q  <= '0;
            shift_q     <= '0;
            tx_cnt_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_hi_q   <= pend_hi_d;
            wr_reg_q    <= wr_reg_d;
            wr_addr_q   <= wr_addr_d;
            changed_q   <= changed_d;
            hold_cnt_q  <= hold_cnt_d;
            shift_q     <= shift_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.tx_valid       = (state_q == RD_TX);
    assign bus.tx_data        = shift_q[31:24];
    assign bus.wr_reg         = wr_reg_q;
    assign bus.wr_reg_addr    = wr_addr_q;
    assign bus.wr_reg_changed = changed_q;
    assign bus.busy           = (state_q != IDLE);

endmodule
